// File: rtl/aes128_round_key_gen.sv
`default_nettype none
// ============================================================================
// Module   : aes128_round_key_gen
// Brief    : Iterative AES-128 key schedule; one 128-bit round key per
//            valid/ready handshake, indices 0..10. Optional reverse order
//            (10..0) via a key store when AES_RK_REVERSE_EN is defined.
//            Round-key bit 127 is the MSB of byte 0 (w0 = rk[127:96]).
// Revision : 1.0  initial release
// ============================================================================
module aes128_round_key_gen #(
    parameter int         NR        = 10,
    parameter logic [7:0] RCON_INIT = 8'h01
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [127:0] key_in,
    input  logic         key_load,
    input  logic         rk_reverse,
    output logic         busy,
    output logic         rk_valid,
    input  logic         rk_ready,
    output logic [127:0] rk_out,
    output logic [3:0]   rk_idx,
    output logic         done
);

    localparam logic [3:0] c_last = 4'(NR);

    localparam logic [2047:0] c_sbox = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EMIT = 2'd1
`ifdef AES_RK_REVERSE_EN
        ,
        S_FILL = 2'd2,
        S_REV  = 2'd3
`endif
    } state_t;

    state_t         r_state;
    state_t         w_state_nxt;
    logic           w_load;
    logic           w_xfer;
    logic           w_advance;
    logic           r_busy;
    logic           r_valid;
    logic           r_done;
    logic [127:0]   r_rk;
    logic [3:0]     r_idx;
    logic [7:0]     r_rcon;
    logic [127:0]   w_rk_next;
    logic [7:0]     w_rcon_next;

    function automatic logic [7:0] f_sbox(input logic [7:0] b);
        return c_sbox[11'd2047 - {b, 3'b000} -: 8];
    endfunction

    // One schedule step: SubWord(RotWord(w3)) ^ rcon, then the w0..w3 ripple.
    function automatic logic [127:0] f_next(input logic [127:0] rk, input logic [7:0] rcon);
        logic [31:0] w0, w1, w2, w3, t;
        t  = {f_sbox(rk[23:16]), f_sbox(rk[15:8]), f_sbox(rk[7:0]), f_sbox(rk[31:24])}
             ^ {rcon, 24'h000000};
        w0 = rk[127:96] ^ t;
        w1 = rk[95:64]  ^ w0;
        w2 = rk[63:32]  ^ w1;
        w3 = rk[31:0]   ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    assign w_rk_next   = f_next(r_rk, r_rcon);
    assign w_rcon_next = {r_rcon[6:0], 1'b0} ^ (r_rcon[7] ? 8'h1b : 8'h00);
    assign w_xfer      = r_valid & rk_ready;

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_advance   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (key_load) begin
                    w_load      = 1'b1;
                    w_state_nxt = S_EMIT;
`ifdef AES_RK_REVERSE_EN
                    if (rk_reverse) w_state_nxt = S_FILL;
`endif
                end
            end
            S_EMIT: begin
                if (w_xfer) begin
                    if (r_idx == c_last) w_state_nxt = S_IDLE;
                    else                 w_advance   = 1'b1;
                end
            end
`ifdef AES_RK_REVERSE_EN
            S_FILL: begin
                w_advance = 1'b1;
                if (r_idx == c_last - 4'd1) w_state_nxt = S_REV;
            end
            S_REV: begin
                if (w_xfer && r_idx == 4'd0) w_state_nxt = S_IDLE;
            end
`endif
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    // Handshake flags follow the next state so they line up with r_rk/r_idx.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy  <= 1'b0;
            r_valid <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_busy  <= (w_state_nxt != S_IDLE);
`ifdef AES_RK_REVERSE_EN
            r_valid <= (w_state_nxt == S_EMIT) || (w_state_nxt == S_REV);
`else
            r_valid <= (w_state_nxt == S_EMIT);
`endif
            r_done  <= (r_state != S_IDLE) && (w_state_nxt == S_IDLE);
        end
    end

`ifdef AES_RK_REVERSE_EN
    logic [127:0] r_store [0:10];
    logic         w_rev_step;

    assign w_rev_step = (r_state == S_REV) && w_xfer && (r_idx != 4'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 11; i++) r_store[i] <= '0;
        end else if (w_load) begin
            r_store[0] <= key_in;
        end else if (r_state == S_FILL) begin
            r_store[r_idx + 4'd1] <= w_rk_next;
        end
    end
`else
    logic w_unused_rev;
    assign w_unused_rev = rk_reverse;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rk   <= '0;
            r_idx  <= '0;
            r_rcon <= RCON_INIT;
        end else if (w_load) begin
            r_rk   <= key_in;
            r_idx  <= '0;
            r_rcon <= RCON_INIT;
        end else if (w_advance) begin
            r_rk   <= w_rk_next;
            r_idx  <= r_idx + 4'd1;
            r_rcon <= w_rcon_next;
        end
`ifdef AES_RK_REVERSE_EN
        else if (w_rev_step) begin
            r_rk   <= r_store[r_idx - 4'd1];
            r_idx  <= r_idx - 4'd1;
        end
`endif
    end

    assign busy     = r_busy;
    assign rk_valid = r_valid;
    assign rk_out   = r_rk;
    assign rk_idx   = r_idx;
    assign done     = r_done;

endmodule
`default_nettype wire

// File: tb/tb_aes128_round_key_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_aes128_round_key_gen
// Brief    : Randomized bench for aes128_round_key_gen against a FIPS-197
//            key-expansion model with an arithmetically derived S-box.
// Revision : 1.0  initial release
// ============================================================================
module tb_aes128_round_key_gen;

    logic         clk = 1'b0;
    logic         rst;
    logic [127:0] key_in;
    logic         key_load;
    logic         rk_reverse;
    logic         busy;
    logic         rk_valid;
    logic         rk_ready;
    logic [127:0] rk_out;
    logic [3:0]   rk_idx;
    logic         done;

    int           n_cmp = 0;
    int           n_mis = 0;
    logic [7:0]   m_sbox [256];
    logic [127:0] m_rk   [11];
    logic [127:0] cap    [11];

    localparam logic [127:0] c_v1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] c_v2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;

    always #5 clk = ~clk;

    aes128_round_key_gen dut (
        .clk(clk), .rst(rst), .key_in(key_in), .key_load(key_load),
        .rk_reverse(rk_reverse), .busy(busy), .rk_valid(rk_valid),
        .rk_ready(rk_ready), .rk_out(rk_out), .rk_idx(rk_idx), .done(done)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = xt(a);
            b = b >> 1;
        end
        return p;
    endfunction

    // S-box = affine transform of the GF(2^8) multiplicative inverse.
    task automatic build_sbox();
        logic [7:0] inv, s;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            s = inv;
            for (int n = 1; n < 5; n++) s = s ^ ((inv << n) | (inv >> (8 - n)));
            m_sbox[x] = s ^ 8'h63;
        end
    endtask

    task automatic build_ref(input logic [127:0] key);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {m_sbox[t[31:24]], m_sbox[t[23:16]], m_sbox[t[15:8]], m_sbox[t[7:0]]};
                t = t ^ {rc, 24'h000000};
                rc = xt(rc);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int k = 0; k < 11; k++) m_rk[k] = {w[4*k], w[4*k+1], w[4*k+2], w[4*k+3]};
    endtask

    // Loads key at the current negedge and follows the handshake until the
    // done cycle (returns with done sampled) or until an injected reset.
    task automatic run(input logic [127:0] key, input bit rev_drv, input bit rev_exp,
                       input int ready_pct, input int inj_idx, input int rst_idx,
                       input string tag);
        int pos = 0;
        int k;
        bit exp_valid, rdy, injected = 1'b0;
        build_ref(key);
        key_in = key; key_load = 1'b1; rk_reverse = rev_drv; rk_ready = 1'b0;
        for (int c = 1; c <= 400; c++) begin
            @(negedge clk);
            key_load = 1'b0; rk_reverse = 1'b0;
            if (pos == 11) begin
                check({tag, ".done"},  done,     1);
                check({tag, ".busy0"}, busy,     0);
                check({tag, ".vld0"},  rk_valid, 0);
                return;
            end
            exp_valid = rev_exp ? (c >= 11) : 1'b1;
            k = rev_exp ? 10 - pos : pos;
            check({tag, ".nodone"}, done,     0);
            check({tag, ".busy"},   busy,     1);
            check({tag, ".valid"},  rk_valid, exp_valid);
            if (exp_valid) begin
                check({tag, ".idx"}, rk_idx, k);
                check({tag, ".rk"},  rk_out, m_rk[k]);
                cap[k] = rk_out;
            end
            if (exp_valid && rst_idx == k) begin
                rk_ready = 1'b1; rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                check({tag, ".rst_busy"},  busy,     0);
                check({tag, ".rst_valid"}, rk_valid, 0);
                check({tag, ".rst_done"},  done,     0);
                check({tag, ".rst_idx"},   rk_idx,   0);
                check({tag, ".rst_rk"},    rk_out,   0);
                for (int j = 0; j < 14; j++) begin
                    @(negedge clk);
                    check({tag, ".rst_nodone"}, done, 0);
                end
                return;
            end
            if (exp_valid && inj_idx == k && !injected) begin
                key_in   = {$urandom, $urandom, $urandom, $urandom} ^ ~key;
                key_load = 1'b1;
                injected = 1'b1;
            end
            rdy = ($urandom_range(99) < ready_pct);
            rk_ready = rdy;
            if (exp_valid && rdy) pos++;
        end
        check({tag, ".timeout"}, 0, 1);
    endtask

    task automatic idle_check(input string tag);
        @(negedge clk);
        check({tag, ".idle_done"},  done,     0);
        check({tag, ".idle_busy"},  busy,     0);
        check({tag, ".idle_valid"}, rk_valid, 0);
    endtask

    initial begin
        rst = 1'b1; key_in = '0; key_load = 1'b0; rk_reverse = 1'b0; rk_ready = 1'b0;
        build_sbox();
        repeat (3) @(negedge clk);
        key_load = 1'b1;
        @(negedge clk);
        check("reset.busy",  busy,     0);
        check("reset.valid", rk_valid, 0);
        check("reset.done",  done,     0);
        check("reset.idx",   rk_idx,   0);
        check("reset.rk",    rk_out,   0);
        rst = 1'b0; key_load = 1'b0;
        @(negedge clk);

        run(c_v1, 1'b0, 1'b0, 100, -1, -1, "v1");
        check("v1.idx1",  cap[1],  128'hd6aa74fdd2af72fadaa678f1d6ab76fe);
        check("v1.idx10", cap[10], 128'h13111d7fe3944a17f307a78b4d2b30c5);
        idle_check("v1");

        run(c_v2, 1'b0, 1'b0, 100, -1, -1, "v2");
        check("v2.idx1",  cap[1],  128'ha0fafe1788542cb123a339392a6c7605);
        check("v2.idx10", cap[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        run(c_v1, 1'b0, 1'b0, 100, -1, -1, "b2b");
        idle_check("b2b");

        for (int i = 0; i < 4; i++) begin
            run({$urandom, $urandom, $urandom, $urandom}, 1'b0, 1'b0, 50, -1, -1, "bp");
            idle_check("bp");
        end

        run(c_v2, 1'b0, 1'b0, 100, 4, -1, "inj");
        idle_check("inj");

        run(c_v1, 1'b0, 1'b0, 100, -1, 6, "rst");
        run(c_v1, 1'b0, 1'b0, 100, -1, -1, "post_rst");
        check("post_rst.idx10", cap[10], 128'h13111d7fe3944a17f307a78b4d2b30c5);
        idle_check("post_rst");

`ifdef AES_RK_REVERSE_EN
        run(c_v1, 1'b1, 1'b1, 100, -1, -1, "rev");
        check("rev.idx10", cap[10], 128'h13111d7fe3944a17f307a78b4d2b30c5);
        check("rev.idx0",  cap[0],  c_v1);
        idle_check("rev");
        for (int i = 0; i < 2; i++) begin
            run({$urandom, $urandom, $urandom, $urandom}, 1'b1, 1'b1, 50, 7, -1, "rev_bp");
            idle_check("rev_bp");
        end
        run(c_v2, 1'b1, 1'b1, 100, -1, 3, "rev_rst");
        run(c_v2, 1'b0, 1'b0, 100, -1, -1, "rev_fwd");
        idle_check("rev_fwd");
`else
        run(c_v1, 1'b1, 1'b0, 100, -1, -1, "norev");
        idle_check("norev");
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
`default_nettype wire
